// File: rtl/dac_spi_writer.sv
// dac_spi_writer: serial writer for a 12-bit DAC with a 16-bit SYNC/SCLK/DIN frame.
// Each accepted write sends one frame {2'b00, mode, value} MSB first.
// SCLK idles high and the DAC samples DIN on its falling edge.
// Each frame is followed by a SYNC-high gap.
// Optional feature macro: DAC_HOLD_REG_EN adds a one-deep hold register.
// That register queues one write that arrives while a frame is in progress.
module dac_spi_writer #(
   parameter int CLK_DIV   = 10,
   parameter int GAP_TICKS = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        write,
   input  logic [11:0] value,
   input  logic [1:0]  mode,
   output logic        cs,
   output logic        sclk,
   output logic        sdi,
   output logic        busy,
   output logic        write_done,
   output logic        pending
);

   localparam int GAP_CYCLES = GAP_TICKS * CLK_DIV;
   localparam int CNT_W      = $clog2(GAP_CYCLES + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [3:0]       bit_r;
   logic             low_half_r;
   logic [15:0]      frame_r;
   logic             cs_r;
   logic             sclk_r;
   logic             sdi_r;
   logic             busy_r;
   logic             write_done_r;

   logic [15:0]      port_word_s;
   logic [15:0]      hold_word_s;
   logic             hold_take_s;
   logic [15:0]      start_word_s;

`ifdef DAC_HOLD_REG_EN
   logic [15:0]      hold_r;
   logic             pending_r;
   logic             hold_load_s;

   // Decide whether the queued word starts a frame and whether a write is queued.
   always_comb begin
      hold_word_s = hold_r;
      if (pending_r && ((state_r == ST_IDLE) || ((state_r == ST_GAP) && (cnt_r == GAP_LAST)))) begin
         hold_take_s = 1'b1;
      end else begin
         hold_take_s = 1'b0;
      end
      // A write seen while a frame runs, or while the queued word is being launched, is queued.
      hold_load_s = write && (busy_r || hold_take_s);
   end

   // Hold register: the last write wins, and it clears when its frame is launched.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_r    <= 16'h0000;
         pending_r <= 1'b0;
      end else if (hold_load_s) begin
         hold_r    <= port_word_s;
         pending_r <= 1'b1;
      end else if (hold_take_s) begin
         hold_r    <= hold_r;
         pending_r <= 1'b0;
      end else begin
         hold_r    <= hold_r;
         pending_r <= pending_r;
      end
   end

   assign pending = pending_r;
`else
   // Without the hold register, writes arriving while busy are simply dropped.
   always_comb begin
      hold_word_s = 16'h0000;
      hold_take_s = 1'b0;
   end

   assign pending = 1'b0;
`endif

   // Frame word sources: the live ports or the queued word.
   always_comb begin
      port_word_s = {2'b00, mode, value};
      if (hold_take_s) begin
         start_word_s = hold_word_s;
      end else begin
         start_word_s = port_word_s;
      end
   end

   // Main sequencer: IDLE -> SETUP -> SHIFT (16 bits, high then low half) -> GAP.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         cnt_r        <= '0;
         bit_r        <= 4'd15;
         low_half_r   <= 1'b0;
         frame_r      <= 16'h0000;
         cs_r         <= 1'b1;
         sclk_r       <= 1'b1;
         sdi_r        <= 1'b0;
         busy_r       <= 1'b0;
         write_done_r <= 1'b0;
      end else begin
         write_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (hold_take_s || write) begin
                  state_r    <= ST_SETUP;
                  cnt_r      <= '0;
                  bit_r      <= 4'd15;
                  low_half_r <= 1'b0;
                  frame_r    <= start_word_s;
                  cs_r       <= 1'b0;
                  sclk_r     <= 1'b1;
                  sdi_r      <= start_word_s[15];
                  busy_r     <= 1'b1;
               end else begin
                  cnt_r  <= '0;
                  cs_r   <= 1'b1;
                  sclk_r <= 1'b1;
                  sdi_r  <= 1'b0;
                  busy_r <= 1'b0;
               end
            end
            ST_SETUP: begin
               if (cnt_r == HALF_LAST) begin
                  state_r <= ST_SHIFT;
                  cnt_r   <= '0;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ST_SHIFT: begin
               if (cnt_r == HALF_LAST) begin
                  cnt_r <= '0;
                  if (!low_half_r) begin
                     sclk_r     <= 1'b0;
                     low_half_r <= 1'b1;
                  end else if (bit_r == 4'd0) begin
                     state_r      <= ST_GAP;
                     low_half_r   <= 1'b0;
                     cs_r         <= 1'b1;
                     sclk_r       <= 1'b1;
                     sdi_r        <= 1'b0;
                     write_done_r <= 1'b1;
                  end else begin
                     // Data moves only together with SCLK returning high.
                     low_half_r <= 1'b0;
                     sclk_r     <= 1'b1;
                     bit_r      <= bit_r - 4'd1;
                     sdi_r      <= frame_r[bit_r - 4'd1];
                  end
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            ST_GAP: begin
               if (cnt_r == GAP_LAST) begin
                  cnt_r <= '0;
                  if (hold_take_s) begin
                     // Back-to-back frame: busy stays high and there is no IDLE cycle.
                     state_r    <= ST_SETUP;
                     bit_r      <= 4'd15;
                     low_half_r <= 1'b0;
                     frame_r    <= start_word_s;
                     cs_r       <= 1'b0;
                     sclk_r     <= 1'b1;
                     sdi_r      <= start_word_s[15];
                     busy_r     <= 1'b1;
                  end else begin
                     state_r <= ST_IDLE;
                     busy_r  <= 1'b0;
                  end
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               cnt_r      <= '0;
               bit_r      <= 4'd15;
               low_half_r <= 1'b0;
               cs_r       <= 1'b1;
               sclk_r     <= 1'b1;
               sdi_r      <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   assign cs         = cs_r;
   assign sclk       = sclk_r;
   assign sdi        = sdi_r;
   assign busy       = busy_r;
   assign write_done = write_done_r;

endmodule

// File: tb/tb_dac_spi_writer.sv
// Directed bench for dac_spi_writer with a scoreboard queue of expected frame words.
// The main instance uses CLK_DIV=2 and GAP_TICKS=2.
// A second instance uses CLK_DIV=10 and is checked for SCLK timing.
module tb_dac_spi_writer;

   logic        clk;
   logic        reset;
   logic        write;
   logic [11:0] value;
   logic [1:0]  mode;
   logic        cs, sclk, sdi, busy, write_done, pending;

   logic        write10;
   logic [11:0] value10;
   logic [1:0]  mode10;
   logic        cs10, sclk10, sdi10, busy10, wd10, pend10;

   int          n_vec = 0;
   int          n_err = 0;
   int          frames_done = 0;
   int          wd_cnt = 0;
   int          exp_busy_len = 70;
   logic [15:0] exp_q[$];

   dac_spi_writer #(.CLK_DIV(2), .GAP_TICKS(2)) dut (
      .clk(clk), .reset(reset), .write(write), .value(value), .mode(mode),
      .cs(cs), .sclk(sclk), .sdi(sdi), .busy(busy), .write_done(write_done), .pending(pending)
   );

   dac_spi_writer #(.CLK_DIV(10), .GAP_TICKS(2)) dut10 (
      .clk(clk), .reset(reset), .write(write10), .value(value10), .mode(mode10),
      .cs(cs10), .sclk(sclk10), .sdi(sdi10), .busy(busy10), .write_done(wd10), .pending(pend10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [11:0] v, input logic [1:0] m);
      @(negedge clk);
      write = 1'b1;
      value = v;
      mode  = m;
      @(posedge clk);
      #1 write = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (frames_done >= n) break;
         @(negedge clk);
      end
      chk("frame_timeout", (frames_done >= n), 1'b1);
   endtask

   task automatic wait_idle(input int budget);
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      chk("idle_timeout", busy, 1'b0);
   endtask

   // Monitor: rebuilds each frame from sdi sampled at SCLK falls and checks frame timing.
   initial begin : monitor
      logic [15:0] shreg;
      logic [15:0] w;
      int nbits, cs_low, busy_run, cs_hi_busy;
      logic prev_sclk, prev_cs, prev_busy;
      shreg = 16'h0000; nbits = 0; cs_low = 0; busy_run = 0; cs_hi_busy = 0;
      prev_sclk = 1'b1; prev_cs = 1'b1; prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            shreg = 16'h0000; nbits = 0; cs_low = 0; busy_run = 0; cs_hi_busy = 0;
         end else begin
            if (!cs && prev_sclk && !sclk) begin
               shreg = {shreg[14:0], sdi};
               nbits++;
            end
            if (!cs) cs_low++;
            if (!cs && prev_cs && cs_hi_busy != 0) chk("gap_cs_high", cs_hi_busy, 4);
            if (cs && !prev_cs) begin
               chk("frame_bits", nbits, 16);
               chk("cs_low_len", cs_low, 66);
               chk("wd_at_cs_rise", write_done, 1'b1);
               chk("frame_expected", (exp_q.size() > 0), 1'b1);
               if (exp_q.size() > 0) begin
                  w = exp_q.pop_front();
                  chk("frame_word", shreg, w);
               end
               frames_done++;
               nbits = 0;
               cs_low = 0;
            end
            if (write_done) wd_cnt++;
            if (busy) busy_run++;
            else if (prev_busy) begin
               chk("busy_len", busy_run, exp_busy_len);
               busy_run = 0;
            end
            if (!busy || !cs) cs_hi_busy = 0;
            else cs_hi_busy++;
         end
         prev_sclk = sclk;
         prev_cs = cs;
         prev_busy = busy;
      end
   end

   initial begin : stim
      int f0, w0, falls, cyc, bc, cl, nf, f1, f2, lowlen, lastfall, wd10_cnt;
      logic ps;
      logic [15:0] w10;
      reset = 1'b1; write = 1'b0; value = 12'h000; mode = 2'b00;
      write10 = 1'b0; value10 = 12'h5A3; mode10 = 2'b00;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_cs", cs, 1'b1);
      chk("rst_sclk", sclk, 1'b1);
      chk("rst_sdi", sdi, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wd", write_done, 1'b0);
      chk("rst_pending", pending, 1'b0);

      // Test 1: basic frame.
      exp_q.push_back(16'h0A5C);
      do_write(12'hA5C, 2'b00);
      chk("t1_busy", busy, 1'b1);
      chk("t1_cs", cs, 1'b0);
      chk("t1_sclk", sclk, 1'b1);
      chk("t1_sdi", sdi, 1'b0);
      wait_frames(1, 200);
      wait_idle(100);
      chk("t1_wd_cnt", wd_cnt, 1);

      // Test 2: power-down mode bits.
      exp_q.push_back(16'h3000);
      do_write(12'h000, 2'b11);
      wait_frames(2, 200);
      wait_idle(100);
      chk("t2_wd_cnt", wd_cnt, 2);

      f0 = frames_done;
      w0 = wd_cnt;
`ifdef DAC_HOLD_REG_EN
      // Test 4: queued writes, last one wins, back-to-back frames.
      exp_busy_len = 140;
      exp_q.push_back(16'h0123);
      exp_q.push_back(16'h0456);
      do_write(12'h123, 2'b00);
      repeat (3) @(posedge clk);
      do_write(12'hFFF, 2'b00);
      chk("t4_pending_set", pending, 1'b1);
      repeat (33) @(posedge clk);
      do_write(12'h456, 2'b00);
      chk("t4_pending_still", pending, 1'b1);
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (!pending) break;
      end
      chk("t4_pending_clr", pending, 1'b0);
      chk("t4_cs_at_clr", cs, 1'b0);
      chk("t4_busy_at_clr", busy, 1'b1);
      wait_frames(f0 + 2, 300);
      wait_idle(100);
      repeat (20) @(negedge clk);
      chk("t4_frames", frames_done - f0, 2);
      chk("t4_wd", wd_cnt - w0, 2);
      exp_busy_len = 70;
`else
      // Test 3: writes while busy are dropped.
      exp_q.push_back(16'h0123);
      do_write(12'h123, 2'b00);
      repeat (3) @(posedge clk);
      do_write(12'hFFF, 2'b00);
      chk("t3_pending_tied", pending, 1'b0);
      repeat (33) @(posedge clk);
      do_write(12'hFFF, 2'b00);
      wait_frames(f0 + 1, 200);
      wait_idle(100);
      repeat (20) @(negedge clk);
      chk("t3_frames", frames_done - f0, 1);
      chk("t3_wd", wd_cnt - w0, 1);
`endif

      // Test 5: reset in the middle of a frame abandons it.
      do_write(12'h3C3, 2'b01);
      falls = 0;
      ps = sclk;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         if (ps && !sclk) falls++;
         ps = sclk;
         if (falls == 8) break;
      end
      chk("t5_reach8", falls, 8);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_cs", cs, 1'b1);
      chk("t5_sclk", sclk, 1'b1);
      chk("t5_sdi", sdi, 1'b0);
      chk("t5_busy", busy, 1'b0);
      chk("t5_wd", write_done, 1'b0);
      @(negedge clk);
      #1 reset = 1'b0;
      f0 = frames_done;
      exp_q.push_back(16'h07FF);
      do_write(12'h7FF, 2'b00);
      wait_frames(f0 + 1, 200);
      wait_idle(100);
      chk("t5_frames", frames_done - f0, 1);
      chk("q_empty", exp_q.size(), 0);

      // Test 6: CLK_DIV=10 timing.
      cyc = 0; bc = 0; cl = 0; nf = 0; f1 = -1; f2 = -1; lowlen = -1; lastfall = 0;
      wd10_cnt = 0; w10 = 16'h0000; ps = 1'b1;
      @(negedge clk);
      write10 = 1'b1;
      @(posedge clk);
      #1 write10 = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         cyc++;
         if (wd10) wd10_cnt++;
         if (!busy10) break;
         bc++;
         if (!cs10) cl++;
         if (ps && !sclk10 && !cs10) begin
            nf++;
            w10 = {w10[14:0], sdi10};
            if (nf == 1) f1 = cyc;
            if (nf == 2) f2 = cyc;
            lastfall = cyc;
         end
         if (!ps && sclk10 && lowlen < 0) lowlen = cyc - lastfall;
         ps = sclk10;
      end
      chk("t6_busy_len", bc, 350);
      chk("t6_cs_low", cl, 330);
      chk("t6_falls", nf, 16);
      chk("t6_period", f2 - f1, 20);
      chk("t6_low_half", lowlen, 10);
      chk("t6_word", w10, 16'h05A3);
      chk("t6_wd", wd10_cnt, 1);
      chk("t6_pending", pend10, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
